shift_2: RTL and testbench
==========================

# shift_2

Parameterised shift-left-by-constant block for the MIPS datapath: multiplies its input by 4 (default shift of 2) for branch-offset word addressing (32→32) and jump-target formation (26→28). It provides a zero-latency combinational result, a lost-bit overflow flag, and a registered copy of both for pipelined consumers.

## Interface
- `width_in`, 32, input operand width (≥1)
- `width_out`, 32, result width (≥1)
- `shamt`, 2, constant left-shift amount (0 ≤ shamt < width_out)

- `clk`  input  1  rising-edge clock for registered outputs
- `rst_n`  input  1  asynchronous, active-low reset
- `en`  input  1  load enable for registered stage
- `in`  input  width_in  operand
- `out`  output  width_out  combinational `in << shamt`, resized
- `ovf`  output  1  combinational: a nonzero bit was discarded
- `out_q`  output  width_out  registered `out`
- `ovf_q`  output  1  registered `ovf`

One clock; reset is asynchronous and active-low.

## Operation
- Form full product P = {in, shamt zero bits}, width width_in+shamt.
- If width_out ≥ width_in+shamt: `out` = P zero-extended in MSBs.
- Else: `out` = P[width_out-1:0]; discarded MSBs P[width_in+shamt-1:width_out] feed `ovf`.
- `ovf` = OR of discarded bits; 0 when nothing is discarded.
- Low shamt bits of `out` always 0.
- No sign extension; operand treated as unsigned.
- Registered stage: on rising `clk` with `en`=1, `out_q`←`out`, `ovf_q`←`ovf`; with `en`=0 hold.
- X/Z on `in` need not be specially handled.

## Timing
- `out`, `ovf`: purely combinational, zero cycles; settle within the same delta/time step as `in` changes.
- `out_q`, `ovf_q`: one-cycle latency after the enabling edge.
- `rst_n` low: `out_q`=0, `ovf_q`=0 immediately, independent of `clk`; combinational outputs unaffected by reset.
- Reset released on a clock edge: that edge does not load; first load on the next enabled edge.
- Reset asserted mid-operation: registered contents discarded, no partial state.

## Configuration
- `SHIFT2_REG_EN`: defined → registered stage implemented as above.
- Not defined → no flops; `out_q` = `out`, `ovf_q` = `ovf` combinationally; `clk`, `rst_n`, `en` remain as ports but are ignored.
- Combinational `out`/`ovf` identical in both builds.

## Test plan
- Default (32→32): `in`=0 → `out`=0, `ovf`=0; `in`=10 → `out`=40, `ovf`=0.
- Default: `in`=32'hFFFF_FFFF → `out`=32'hFFFF_FFFC, `ovf`=1; `in`=32'h4000_0000 → `out`=0, `ovf`=1.
- width_in=26, width_out=28: `in`=0 → 0; `in`=10 → 40; `in`=26'h3FF_FFFF → `out`=28'hFFF_FFFC, `ovf`=0.
- Registered (`SHIFT2_REG_EN`): `rst_n`=0 → `out_q`=0, `ovf_q`=0 without clock; release, `en`=1, `in`=10 → `out_q`=40 after one edge.
- Registered hold: `en`=0, change `in` to 7 → `out_q` stays 40 while `out`=28; assert `rst_n`=0 between edges → `out_q`=0 immediately.
- shamt=0, width_in=width_out=32: `out`=`in`, `ovf`=0 for all-ones.

Source files
------------

// File: rtl/shift_2.sv
// Constant left shift (x4 by default) with discarded-bit overflow flag and optional output register.
// Define SHIFT2_REG_EN to build the registered out_q/ovf_q stage; otherwise they mirror out/ovf.
module shift_2 #(
   parameter int unsigned width_in  = 32,
   parameter int unsigned width_out = 32,
   parameter int unsigned shamt     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [width_in-1:0]  in,
   output logic [width_out-1:0] out,
   output logic                 ovf,
   output logic [width_out-1:0] out_q,
   output logic                 ovf_q
);

   localparam int unsigned PW = width_in + shamt;

   logic [PW-1:0] w_prod;

   // Widen before shifting so no operand bit is lost ahead of the resize.
   assign w_prod = PW'(in) << shamt;

   generate
      if (width_out >= PW) begin : g_ext
         assign out = width_out'(w_prod);
         assign ovf = 1'b0;
      end else begin : g_trunc
         assign out = w_prod[width_out-1:0];
         assign ovf = |w_prod[PW-1:width_out];
      end
   endgenerate

`ifdef SHIFT2_REG_EN
   logic [width_out-1:0] r_out_q;
   logic                 r_ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q <= '0;
         r_ovf_q <= 1'b0;
      end else if (en) begin
         r_out_q <= out;
         r_ovf_q <= ovf;
      end
   end

   assign out_q = r_out_q;
   assign ovf_q = r_ovf_q;
`else
   // Clock, reset and enable are kept as ports for drop-in use but have no effect here.
   logic w_unused_ok;
   assign w_unused_ok = ^{clk, rst_n, en};

   assign out_q = out;
   assign ovf_q = ovf;
`endif

endmodule

// File: tb/tb_shift_2.sv
// Scoreboard bench for shift_2: five parameterisations driven together, checked against an arithmetic model.
module tb_shift_2;

   localparam int unsigned N = 5;
   localparam int unsigned WI[N] = '{32, 26, 32, 8, 8};
   localparam int unsigned WO[N] = '{32, 28, 32, 16, 4};
   localparam int unsigned SH[N] = '{2, 2, 0, 3, 1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;

   logic [31:0] in0 = '0;  logic [31:0] out0, oq0;  logic f0, fq0;
   logic [25:0] in1 = '0;  logic [27:0] out1, oq1;  logic f1, fq1;
   logic [31:0] in2 = '0;  logic [31:0] out2, oq2;  logic f2, fq2;
   logic [7:0]  in3 = '0;  logic [15:0] out3, oq3;  logic f3, fq3;
   logic [7:0]  in4 = '0;  logic [3:0]  out4, oq4;  logic f4, fq4;

   always #5 clk = ~clk;

   shift_2 #(.width_in(32), .width_out(32), .shamt(2)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in0), .out(out0), .ovf(f0), .out_q(oq0), .ovf_q(fq0));
   shift_2 #(.width_in(26), .width_out(28), .shamt(2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in1), .out(out1), .ovf(f1), .out_q(oq1), .ovf_q(fq1));
   shift_2 #(.width_in(32), .width_out(32), .shamt(0)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in2), .out(out2), .ovf(f2), .out_q(oq2), .ovf_q(fq2));
   shift_2 #(.width_in(8), .width_out(16), .shamt(3)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in3), .out(out3), .ovf(f3), .out_q(oq3), .ovf_q(fq3));
   shift_2 #(.width_in(8), .width_out(4), .shamt(1)) u4 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in4), .out(out4), .ovf(f4), .out_q(oq4), .ovf_q(fq4));

   typedef struct packed {
      logic [N-1:0][31:0] o;
      logic [N-1:0]       f;
      logic [N-1:0][31:0] q;
      logic [N-1:0]       fq;
   } exp_t;

   exp_t sb[$];
   exp_t mx;
   logic [N-1:0][31:0] mq = '0;
   logic [N-1:0]       mf = '0;
   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Multiply by 2**sh, then split the product at width wo into result and discarded part.
   function automatic void ref_shift(input longint unsigned x, input int unsigned wi,
                                     input int unsigned sh, input int unsigned wo,
                                     output logic [31:0] o, output logic f);
      longint unsigned xm, p;
      xm = x % (64'd1 << wi);
      p  = xm * (64'd1 << sh);
      o  = 32'(p % (64'd1 << wo));
      f  = (p / (64'd1 << wo)) != 0;
   endfunction

   function automatic void sample(output logic [N-1:0][31:0] ao, output logic [N-1:0] af,
                                  output logic [N-1:0][31:0] aq, output logic [N-1:0] afq);
      ao[0] = out0;       aq[0] = oq0;       af[0] = f0; afq[0] = fq0;
      ao[1] = 32'(out1);  aq[1] = 32'(oq1);  af[1] = f1; afq[1] = fq1;
      ao[2] = out2;       aq[2] = oq2;       af[2] = f2; afq[2] = fq2;
      ao[3] = 32'(out3);  aq[3] = 32'(oq3);  af[3] = f3; afq[3] = fq3;
      ao[4] = 32'(out4);  aq[4] = 32'(oq4);  af[4] = f4; afq[4] = fq4;
   endfunction

   task automatic issue(input logic [N-1:0][31:0] v, input logic e, input logic r);
      exp_t x;
      logic [31:0] o;
      logic f;
      logic [N-1:0][31:0] ao, aq;
      logic [N-1:0] af, afq;
      @(negedge clk);
      in0 = v[0]; in1 = v[1][25:0]; in2 = v[2]; in3 = v[3][7:0]; in4 = v[4][7:0];
      en = e; rst_n = r;
      for (int i = 0; i < N; i++) begin
         ref_shift(64'(v[i]), WI[i], SH[i], WO[i], o, f);
         x.o[i] = o; x.f[i] = f;
`ifdef SHIFT2_REG_EN
         if (!r) begin
            mq[i] = '0; mf[i] = 1'b0;
         end else if (e) begin
            mq[i] = o; mf[i] = f;
         end
`else
         mq[i] = o; mf[i] = f;
`endif
         x.q[i] = mq[i]; x.fq[i] = mf[i];
      end
      sb.push_back(x);
      if (!r) begin
         #1;
         sample(ao, af, aq, afq);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_out_q[%0d]", i), aq[i], mq[i]);
            chk($sformatf("rst_ovf_q[%0d]", i), 32'(afq[i]), 32'(mf[i]));
         end
      end
   endtask

   always @(posedge clk) begin
      logic [N-1:0][31:0] ao, aq;
      logic [N-1:0] af, afq;
      #1;
      if (sb.size() != 0) begin
         mx = sb.pop_front();
         sample(ao, af, aq, afq);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("out[%0d]", i),   ao[i],          mx.o[i]);
            chk($sformatf("ovf[%0d]", i),   32'(af[i]),     32'(mx.f[i]));
            chk($sformatf("out_q[%0d]", i), aq[i],          mx.q[i]);
            chk($sformatf("ovf_q[%0d]", i), 32'(afq[i]),    32'(mx.fq[i]));
         end
      end
   end

   initial begin
      logic [N-1:0][31:0] ao, aq;
      logic [N-1:0] af, afq;
      logic [N-1:0][31:0] v;
      #1;
      sample(ao, af, aq, afq);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("init_out_q[%0d]", i), aq[i], 32'd0);
         chk($sformatf("init_out[%0d]", i),   ao[i], 32'd0);
      end

      issue({N{32'd0}}, 1'b1, 1'b0);
      issue({N{32'd0}}, 1'b1, 1'b1);
      issue({N{32'd10}}, 1'b1, 1'b1);
      issue({N{32'hFFFF_FFFF}}, 1'b1, 1'b1);
      issue({N{32'h4000_0000}}, 1'b1, 1'b1);
      issue({N{32'h03FF_FFFF}}, 1'b1, 1'b1);
      issue({N{32'd10}}, 1'b1, 1'b1);
      issue({N{32'd7}}, 1'b0, 1'b1);
      issue({N{32'd7}}, 1'b0, 1'b0);
      issue({N{32'd7}}, 1'b1, 1'b1);
      issue({N{32'd7}}, 1'b1, 1'b1);

      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) v[i] = $urandom;
         issue(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) != 0));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
